// File: rtl/seven_segment_scan_driver_if.sv
// Display-driver bus: shadow-load inputs from the datapath and the multiplexed pin outputs.
// master = datapath/bench side, slave = the scan driver.
interface seven_segment_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [6:0]            seg;
    logic                  dp_out;
    logic [DIGITS-1:0]     an;

    modport master (
        output load, value, dp, blank,
        input  seg, dp_out, an
    );

    modport slave (
        input  load, value, dp, blank,
        output seg, dp_out, an
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver with guard interval, blanking and decimal points.
// Optional LEADING_ZERO_SUPPRESS_EN: digits above the most significant nonzero nibble go dark.
module seven_segment_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    seven_segment_scan_driver_if.slave   bus
);
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    logic [VAL_W-1:0]  sh_value;
    logic [DIGITS-1:0] sh_dp;
    logic [DIGITS-1:0] sh_blank;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic [6:0]        seg_q;
    logic              dp_out_q;
    logic [DIGITS-1:0] an_q;

    logic [DIGITS-1:0] dark;
    logic [3:0]        cur_nib;
    logic              guard_phase;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Shadow copy of the displayed value; reset wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (bus.load) begin
            sh_value <= bus.value;
            sh_dp    <= bus.dp;
            sh_blank <= bus.blank;
        end
    end

    // Slot prescaler and digit index; blanking never touches this timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic seen_nonzero;

    // Digits above the top nonzero nibble are dark; digit 0 always stays eligible.
    always_comb begin
        dark         = sh_blank;
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (sh_value[4*i +: 4] != 4'h0) seen_nonzero = 1'b1;
            if (!seen_nonzero) dark[i] = 1'b1;
        end
    end
`else
    always_comb begin
        dark = sh_blank;
    end
`endif

    always_comb begin
        cur_nib = sh_value[4*int'(idx) +: 4];
    end

    assign guard_phase = (32'(cnt) < GUARD);

    // Registered pin outputs, computed from the state held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q     <= '0;
            seg_q    <= '0;
            dp_out_q <= 1'b0;
        end else if (guard_phase || dark[idx]) begin
            an_q     <= '0;
            seg_q    <= '0;
            dp_out_q <= 1'b0;
        end else begin
            an_q     <= DIGITS'(1) << idx;
            seg_q    <= decode(cur_nib);
            dp_out_q <= sh_dp[idx];
        end
    end

    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
    assign bus.dp_out = dp_out_q;
endmodule
